acc_mailbox: RTL and testbench

Memory-mapped mailbox between the core's data-RAM port and the hardware accelerator datapath. Decodes the accelerator address window on the shared single-port bus, buffers operand words in a transmit FIFO, streams them to the accelerator over a valid/ready interface, and collects results in a receive FIFO for core readback. Read latency matches the neighbouring SRAM (one cycle), so the bus can mux `rdata_o` without extra wait logic.

---
 rtl/acc_mb_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/acc_mailbox.sv | 213 +++++++++++++++++++++
 tb/tb_acc_mailbox.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_mb_pkg.sv
// Shared constants and types for the accelerator mailbox: register map,
// STATUS/CTRL bit positions and the job-sequencing state enum.
package acc_mb_pkg;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_TX     = 3'd2;
    localparam logic [2:0] OFF_RX     = 3'd3;
    localparam logic [2:0] OFF_LEN    = 3'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_OVF      = 4;
    localparam int ST_UNF      = 5;
    localparam int ST_RXCNT    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } acc_mb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, synchronous reset
// and flush. A push into a full FIFO succeeds when a pop happens alongside.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW:0]      cnt_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign pop_ok_s  = pop && (cnt_r != {(AW+1){1'b0}});
    assign push_ok_s = push && ((cnt_r != FULL_CNT) || pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign full      = (cnt_r == FULL_CNT);
    assign empty     = (cnt_r == {(AW+1){1'b0}});
    assign count     = cnt_r;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= {AW{1'b0}};
            cnt_r    <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/acc_mailbox.sv
// Memory-mapped mailbox: bus register window, TX operand FIFO streamed to the
// accelerator, RX result FIFO read back by the core, job sequencing FSM.
module acc_mailbox
    import acc_mb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 15,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] WIN_BASE   = 15'h0400,
    parameter int                    FIFO_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      hit_o,
    output logic                      acc_valid_o,
    input  logic                      acc_ready_i,
    output logic [DATA_WIDTH-1:0]     acc_data_o,
    input  logic                      res_valid_i,
    output logic                      res_ready_o,
    input  logic [DATA_WIDTH-1:0]     res_data_i,
    output logic                      irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    acc_mb_state_e         state_r, state_nxt_s;
    logic [15:0]           len_r, sent_r, rcvd_r, sent_nxt_s, rcvd_nxt_s;
    logic                  ovf_r, unf_r;
    logic                  hit_s, wr_s, rd_s;
    logic [2:0]            off_s;
    logic                  ctrl_wr_s, start_s, clear_s, status_rd_s, len_wr_s;
    logic                  tx_push_s, rx_pop_s, tx_hs_s, rx_hs_s;
    logic [DATA_WIDTH-1:0] tx_head_s, rx_head_s, status_s, rd_mux_s;
    logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic [CW-1:0]         tx_count_s, rx_count_s;

    assign hit_s       = en_i && (addr_i[ADDR_WIDTH-1:5] == WIN_BASE[ADDR_WIDTH-1:5]);
    assign off_s       = addr_i[4:2];
    assign wr_s        = hit_s && we_i;
    assign rd_s        = hit_s && !we_i;
    assign ctrl_wr_s   = wr_s && (off_s == OFF_CTRL);
    assign clear_s     = ctrl_wr_s && wdata_i[CTRL_CLEAR];
    assign start_s     = ctrl_wr_s && wdata_i[CTRL_START] && !wdata_i[CTRL_CLEAR];
    assign status_rd_s = rd_s && (off_s == OFF_STATUS);
    assign len_wr_s    = wr_s && (off_s == OFF_LEN);
    assign tx_push_s   = wr_s && (off_s == OFF_TX) && (&be_i);
    assign rx_pop_s    = rd_s && (off_s == OFF_RX);

    // Valid only while words remain owed to the current job, so surplus
    // TX entries never leak past LEN and valid cannot drop mid-stall.
    assign acc_valid_o = (state_r == RUN) && !tx_empty_s && (sent_r != len_r);
    assign acc_data_o  = tx_head_s;
    assign res_ready_o = ((state_r == RUN) || (state_r == WAIT)) && !rx_full_s;
    assign irq_o       = (state_r == DONE);
    assign tx_hs_s     = acc_valid_o && acc_ready_i;
    assign rx_hs_s     = res_valid_i && res_ready_o;

    assign sent_nxt_s  = sent_r + {15'd0, tx_hs_s};
    assign rcvd_nxt_s  = (rx_hs_s && (rcvd_r != len_r)) ? (rcvd_r + 16'd1) : rcvd_r;

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst_i),
        .flush (clear_s),
        .push  (tx_push_s),
        .wdata (wdata_i),
        .pop   (tx_hs_s),
        .rdata (tx_head_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst_i),
        .flush (clear_s),
        .push  (rx_hs_s),
        .wdata (res_data_i),
        .pop   (rx_pop_s),
        .rdata (rx_head_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    // Next-state decode; uses next counter values so DONE follows the final
    // result handshake by exactly one cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = (len_r == 16'd0) ? DONE : RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (sent_nxt_s == len_r) begin
                    state_nxt_s = (rcvd_nxt_s == len_r) ? DONE : WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            WAIT: begin
                if (rcvd_nxt_s == len_r) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                if (status_rd_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        if (clear_s) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job word counters; restart from zero on an accepted START.
    always_ff @(posedge clk) begin
        if (rst_i || clear_s || (start_s && (state_r == IDLE))) begin
            sent_r <= 16'd0;
            rcvd_r <= 16'd0;
        end else begin
            sent_r <= sent_nxt_s;
            rcvd_r <= rcvd_nxt_s;
        end
    end

    // LEN register, byte-writable while idle.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            len_r <= 16'd0;
        end else if (len_wr_s && (state_r == IDLE)) begin
            if (be_i[0]) len_r[7:0]  <= wdata_i[7:0];
            if (be_i[1]) len_r[15:8] <= wdata_i[15:8];
        end
    end

    // Sticky error flags, cleared by a STATUS read.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            ovf_r <= 1'b0;
            unf_r <= 1'b0;
        end else begin
            if (status_rd_s) begin
                ovf_r <= 1'b0;
                unf_r <= 1'b0;
            end
            if (tx_push_s && tx_full_s && !tx_hs_s) ovf_r <= 1'b1;
            if (rx_pop_s && rx_empty_s)             unf_r <= 1'b1;
        end
    end

    // Read data selection for the registered bus response.
    always_comb begin
        status_s                   = '0;
        status_s[ST_BUSY]          = (state_r == RUN) || (state_r == WAIT);
        status_s[ST_DONE]          = (state_r == DONE);
        status_s[ST_TX_FULL]       = tx_full_s;
        status_s[ST_RX_EMPTY]      = rx_empty_s;
        status_s[ST_OVF]           = ovf_r;
        status_s[ST_UNF]           = unf_r;
        status_s[ST_RXCNT +: 16]   = 16'(rx_count_s);
        rd_mux_s                   = '0;
        if (rd_s) begin
            case (off_s)
                OFF_STATUS: rd_mux_s = status_s;
                OFF_RX:     rd_mux_s = rx_empty_s ? '0 : rx_head_s;
                OFF_LEN:    rd_mux_s[15:0] = len_r;
                default:    rd_mux_s = '0;
            endcase
        end else begin
            rd_mux_s = '0;
        end
    end

    // Registered bus outputs (one-cycle read latency like the SRAM).
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_o <= '0;
            hit_o   <= 1'b0;
        end else begin
            rdata_o <= rd_mux_s;
            hit_o   <= hit_s;
        end
    end

endmodule

// File: tb/tb_acc_mailbox.sv
// Randomized scoreboard bench for acc_mailbox: bus responses and operand
// stream are checked against a queue-based model of the mailbox behaviour.
module tb_acc_mailbox;
    import acc_mb_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [14:0] BASE  = 15'h0400;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, we = 1'b0;
    logic [14:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata, acc_data, res_data = '0;
    logic        hit, acc_valid, acc_ready = 1'b0, res_valid = 1'b0, res_ready, irq;

    acc_mailbox dut (
        .clk(clk), .rst_i(rst), .en_i(en), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .rdata_o(rdata), .hit_o(hit),
        .acc_valid_o(acc_valid), .acc_ready_i(acc_ready), .acc_data_o(acc_data),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
        .irq_o(irq)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, cyc = 0, acc_xfers = 0;
    logic [31:0] exp_rd_q[$], exp_acc[$], pend[$], m_rx[$];
    logic        exp_hit_q[$];
    logic [15:0] m_len = '0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;
    int          m_phase = 0;            // 0 idle, 1 busy, 2 done
    int          ready_mode = 0, res_limit = -1, res_pct = 100, last_res_cyc = 0;
    logic        irq_timing_en = 1'b0, res_hs = 1'b0, acc_seen = 1'b0;
    logic        stall_prev = 1'b0, irq_prev = 1'b0;
    logic [31:0] stall_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // The accelerator model returns high bits unchanged, low byte = low nibble twice.
    function automatic logic [31:0] res_of(input logic [31:0] x);
        return {x[31:8], 8'h00} ^ {24'h0, x[3:0], x[3:0]};
    endfunction

    function automatic logic [31:0] status_exp();
        logic [31:0] s = '0;
        s[ST_BUSY]        = (m_phase == 1);
        s[ST_DONE]        = (m_phase == 2);
        s[ST_TX_FULL]     = (exp_acc.size() >= DEPTH);
        s[ST_RX_EMPTY]    = (m_rx.size() == 0);
        s[ST_OVF]         = m_ovf;
        s[ST_UNF]         = m_unf;
        s[ST_RXCNT +: 16] = 16'(m_rx.size());
        return s;
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        acc_seen <= en;
    end

    // Bus response monitor.
    always @(negedge clk) begin
        if (acc_seen) begin
            check("rd_queue_nonempty", 32'(exp_rd_q.size() != 0), 32'd1);
            if (exp_rd_q.size() != 0) begin
                check("rdata", rdata, exp_rd_q.pop_front());
                check("hit", 32'(hit), 32'(exp_hit_q.pop_front()));
            end
        end
    end

    // Stream monitor: operand order, hold-while-stalled, result handshakes, irq latency.
    always @(negedge clk) begin
        logic [31:0] e;
        if (stall_prev) begin
            check("acc_hold_valid", 32'(acc_valid), 32'd1);
            check("acc_hold_data", acc_data, stall_data);
        end
        stall_prev = acc_valid && !acc_ready;
        stall_data = acc_data;
        if (acc_valid && acc_ready) begin
            acc_xfers++;
            check("acc_expected_xfer", 32'(exp_acc.size() != 0), 32'd1);
            if (exp_acc.size() != 0) begin
                e = exp_acc.pop_front();
                check("acc_data", acc_data, e);
                pend.push_back(res_of(e));
            end
        end
        if (res_valid && res_ready) begin
            res_hs       = 1'b1;
            last_res_cyc = cyc;
        end
        if (irq && !irq_prev && irq_timing_en)
            check("irq_rise_latency", 32'(cyc - last_res_cyc), 32'd1);
        irq_prev = irq;
    end

    // Accelerator-side drivers.
    always @(posedge clk) begin
        #2;
        if (res_hs) begin
            res_hs = 1'b0;
            if (pend.size() != 0) m_rx.push_back(pend.pop_front());
            if (res_limit > 0) res_limit--;
            res_valid = 1'b0;
        end
        if (!res_valid && pend.size() != 0 && res_limit != 0 &&
            $urandom_range(99) < res_pct) begin
            res_valid = 1'b1;
            res_data  = pend[0];
        end
        case (ready_mode)
            0:       acc_ready = 1'b1;
            1:       acc_ready = ~acc_ready;
            2:       acc_ready = 1'($urandom_range(1));
            default: acc_ready = 1'b0;
        endcase
    end

    task automatic bus(input logic w, input logic [14:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] exp_r, input logic exp_h);
        @(posedge clk); #1;
        en = 1'b1; we = w; addr = a; wdata = d; be = b;
        exp_rd_q.push_back(exp_r);
        exp_hit_q.push_back(exp_h);
        @(posedge clk); #1;
        en = 1'b0; we = 1'b0;
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [31:0] d);
        case (off)
            OFF_CTRL: begin
                if (d[CTRL_CLEAR]) begin
                    exp_acc.delete(); m_rx.delete(); pend.delete(); m_phase = 0;
                end else if (d[CTRL_START] && m_phase == 0) begin
                    m_phase = (m_len == 16'd0) ? 2 : 1;
                end
            end
            OFF_TX:  if (exp_acc.size() >= DEPTH) m_ovf = 1'b1; else exp_acc.push_back(d);
            OFF_LEN: if (m_phase == 0) m_len = d[15:0];
            default: ;
        endcase
        bus(1'b1, BASE + 15'({off, 2'b00}), d, 4'hF, 32'd0, 1'b1);
    endtask

    task automatic rd_reg(input logic [2:0] off);
        logic [31:0] e = '0;
        case (off)
            OFF_STATUS: begin
                e = status_exp();
                m_ovf = 1'b0; m_unf = 1'b0;
                if (m_phase == 2) m_phase = 0;
            end
            OFF_RX: begin
                if (m_rx.size() == 0) m_unf = 1'b1;
                else e = m_rx.pop_front();
            end
            OFF_LEN: e = {16'h0, m_len};
            default: e = '0;
        endcase
        bus(1'b0, BASE + 15'({off, 2'b00}), 32'd0, 4'hF, e, 1'b1);
    endtask

    task automatic wait_irq();
        int n = 0;
        while (!irq && n < 300) begin @(negedge clk); n++; end
        check("irq_asserted", 32'(irq), 32'd1);
        m_phase = 2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_hit"}, 32'(hit), 32'd0);
        check({tag, "_acc_valid"}, 32'(acc_valid), 32'd0);
        check({tag, "_res_ready"}, 32'(res_ready), 32'd0);
        check({tag, "_irq"}, 32'(irq), 32'd0);
    endtask

    // Start a 4-word job whose accelerator returns only two results.
    task automatic half_job();
        int n = 0;
        wr_reg(OFF_LEN, 32'd4);
        for (int i = 0; i < 4; i++) wr_reg(OFF_TX, $urandom);
        ready_mode = 0; res_limit = 2; res_pct = 100; irq_timing_en = 1'b0;
        wr_reg(OFF_CTRL, 32'h1);
        while ((m_rx.size() != 2 || exp_acc.size() != 0) && n < 300) begin @(negedge clk); n++; end
        check("half_job_two_results", 32'(m_rx.size()), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("wait_res_ready", 32'(res_ready), 32'd1);
    endtask

    initial begin
        int len, nb, x0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        rd_reg(OFF_STATUS);
        rd_reg(OFF_LEN);

        // Basic three-word job.
        irq_timing_en = 1'b1; ready_mode = 0; res_pct = 100; res_limit = -1;
        wr_reg(OFF_LEN, 32'd3);
        wr_reg(OFF_TX, 32'hA1); wr_reg(OFF_TX, 32'hA2); wr_reg(OFF_TX, 32'hA3);
        wr_reg(OFF_CTRL, 32'h1);
        wait_irq();
        for (int i = 0; i < 3; i++) rd_reg(OFF_RX);
        rd_reg(OFF_STATUS);
        check("irq_fall", 32'(irq), 32'd0);

        // TX overflow, sticky flag cleared by reading.
        for (int i = 0; i < 9; i++) wr_reg(OFF_TX, $urandom);
        rd_reg(OFF_STATUS);
        rd_reg(OFF_STATUS);
        wr_reg(OFF_CTRL, 32'h2);
        rd_reg(OFF_STATUS);

        // RX underflow.
        rd_reg(OFF_RX);
        rd_reg(OFF_STATUS);
        rd_reg(OFF_STATUS);

        // Stall handling with ready toggling every cycle.
        wr_reg(OFF_LEN, 32'd4);
        for (int i = 0; i < 4; i++) wr_reg(OFF_TX, $urandom);
        x0 = acc_xfers; ready_mode = 1;
        wr_reg(OFF_CTRL, 32'h1);
        wait_irq();
        check("toggle_xfer_count", 32'(acc_xfers - x0), 32'd4);
        for (int i = 0; i < 4; i++) rd_reg(OFF_RX);
        rd_reg(OFF_STATUS);
        ready_mode = 0;

        // Zero-length job finishes immediately with no stream traffic.
        irq_timing_en = 1'b0; x0 = acc_xfers;
        wr_reg(OFF_LEN, 32'd0);
        wr_reg(OFF_CTRL, 32'h1);
        check("len0_irq", 32'(irq), 32'd1);
        rd_reg(OFF_STATUS);
        check("len0_no_xfer", 32'(acc_xfers - x0), 32'd0);
        check("len0_irq_fall", 32'(irq), 32'd0);

        // CLEAR while waiting for results; START+CLEAR together acts as CLEAR.
        half_job();
        rd_reg(OFF_STATUS);
        wr_reg(OFF_CTRL, 32'h3);
        #1;
        check("clear_res_ready", 32'(res_ready), 32'd0);
        check("clear_irq", 32'(irq), 32'd0);
        rd_reg(OFF_STATUS);
        res_limit = -1;

        // Reset while waiting, with a sticky flag pending.
        rd_reg(OFF_RX);
        half_job();
        @(posedge clk); #1;
        rst = 1'b1;
        exp_acc.delete(); m_rx.delete(); pend.delete();
        m_len = '0; m_ovf = 1'b0; m_unf = 1'b0; m_phase = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("midjob_reset");
        rst = 1'b0; res_limit = -1;
        rd_reg(OFF_STATUS);
        rd_reg(OFF_LEN);

        // Randomized jobs with interleaved pushes, stalls and stray accesses.
        for (int it = 0; it < 16; it++) begin
            len = $urandom_range(8, 1);
            nb  = $urandom_range(len, 0);
            ready_mode = 2; res_pct = $urandom_range(100, 30); irq_timing_en = 1'b1;
            wr_reg(OFF_LEN, 32'(len));
            for (int i = 0; i < nb; i++) wr_reg(OFF_TX, $urandom);
            wr_reg(OFF_CTRL, 32'h1);
            bus(1'b1, BASE + 15'h0008, $urandom, 4'h7, 32'd0, 1'b1);
            bus(1'b1, BASE + 15'h0028, $urandom, 4'hF, 32'd0, 1'b0);
            bus(1'b0, BASE - 15'h0004, 32'd0, 4'hF, 32'd0, 1'b0);
            for (int i = nb; i < len; i++) wr_reg(OFF_TX, $urandom);
            wait_irq();
            for (int i = 0; i < len; i++) rd_reg(OFF_RX);
            if ($urandom_range(2) == 0) rd_reg(OFF_RX);
            rd_reg(OFF_STATUS);
            check("rand_irq_fall", 32'(irq), 32'd0);
        end

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_rd_q.size() + exp_acc.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
